// File: rtl/logn.sv
// Sequential fixed-point natural log: y = ln(x0) for x0 in (0, 1.0], Q1.8 format.
// Multiplicative normalization with (1+2^-k) factors; fixed 10-cycle start-to-done latency.
module logn #(
  parameter int unsigned W     = 10,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned ITERS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] x0,
  output logic [W-1:0] y,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int unsigned AW  = W + 2;
  localparam int unsigned SW  = 2 * W;
  localparam int unsigned KW  = 4;
  localparam int unsigned ONE = 1 << FRAC;

  localparam logic [W-1:0]         ONE_V   = W'(ONE);
  localparam logic [W-1:0]         SAT_V   = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [AW-1:0] SAT_LIM = -AW'(signed'(ONE * 2));
  localparam logic [AW-1:0]        LN2     = AW'(177);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_ITER = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [W-1:0]          x_acc_q, x_acc_d;
  logic signed [AW-1:0]  y_acc_q, y_acc_d;
  logic [KW-1:0]         k_q, k_d;
  logic                  err_flag_q, err_flag_d;
  logic [W-1:0]          y_q, y_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [KW-1:0]         shamt_c;
  logic [W-1:0]          t_c;

  // ln(1+2^-k) in Q.8, rounded
  function automatic logic signed [AW-1:0] ln_tab(input logic [KW-1:0] k);
    case (k)
      4'd1:    ln_tab = AW'(104);
      4'd2:    ln_tab = AW'(57);
      4'd3:    ln_tab = AW'(30);
      4'd4:    ln_tab = AW'(16);
      4'd5:    ln_tab = AW'(8);
      4'd6:    ln_tab = AW'(4);
      4'd7:    ln_tab = AW'(2);
      4'd8:    ln_tab = AW'(1);
      default: ln_tab = AW'(0);
    endcase
  endfunction

  // Smallest left shift that lifts x_acc above 0.5; a zero operand falls through to 8
  always_comb begin
    shamt_c = KW'(8);
    for (int i = 8; i >= 0; i--) begin
      if ((SW'(x_acc_q) << i) > SW'(ONE / 2)) shamt_c = KW'(i);
    end
  end

  assign t_c = x_acc_q + (x_acc_q >> k_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      x_acc_q    <= '0;
      y_acc_q    <= '0;
      k_q        <= '0;
      err_flag_q <= 1'b0;
      y_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_acc_q    <= x_acc_d;
      y_acc_q    <= y_acc_d;
      k_q        <= k_d;
      err_flag_q <= err_flag_d;
      y_q        <= y_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    x_acc_d    = x_acc_q;
    y_acc_d    = y_acc_q;
    k_d        = k_q;
    err_flag_d = err_flag_q;
    y_d        = y_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_acc_d    = x0;
          y_acc_d    = '0;
          err_flag_d = (x0 == '0) || x0[W-1] || (x0 > ONE_V);
          busy_d     = 1'b1;
          state_d    = S_NORM;
        end
      end
      S_NORM: begin
        x_acc_d = x_acc_q << shamt_c;
        y_acc_d = -signed'(AW'(shamt_c) * LN2);
        k_d     = KW'(1);
        state_d = S_ITER;
      end
      S_ITER: begin
        if (t_c <= ONE_V) begin
          x_acc_d = t_c;
          y_acc_d = y_acc_q - ln_tab(k_q);
        end
        k_d = k_q + KW'(1);
        if (k_q == KW'(ITERS)) state_d = S_OUT;
      end
      S_OUT: begin
        if (err_flag_q || (y_acc_q < SAT_LIM)) y_d = SAT_V;
        else                                    y_d = y_acc_q[W-1:0];
        err_d   = err_flag_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign y    = y_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
